// File: rtl/relay_pkg.sv
// Shared types and default timing for the relay-timed memory stage.
package relay_pkg;

    localparam int ADDR_BITS      = 16;
    localparam int DATA_BITS      = 8;

    // Default relay timing: address settle cycles and access cycles.
    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_ACCESS_CYC = 3;

    typedef logic [ADDR_BITS-1:0] addr_t;
    typedef logic [DATA_BITS-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/relay_ram.sv
// Single-port synchronous RAM backing the memory stage. Kept separate so the
// array can be swapped for a model with real relay timing later.
// Read data is registered every clock from the current address; a write on
// the same edge returns the previous contents.
module relay_ram #(
    parameter int DATA_W    = 8,
    parameter int MEM_WORDS = 32768,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    // Array write and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage downstream of the M1/M2 address register pair.
// Captures address/data/op on a request pulse and runs a fixed-length
// SETUP -> ACCESS -> HOLD cycle against relay_ram, then pulses done.
// Optional feature macro: MEM_WPROT_EN (writes at or above ROM_BASE are
// blocked and flagged on err_wprot).
module mem_access_unit
    import relay_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter int                MEM_WORDS  = 32768,
    parameter int                SETUP_CYC  = DEF_SETUP_CYC,
    parameter int                ACCESS_CYC = DEF_ACCESS_CYC,
    parameter logic [ADDR_W-1:0] ROM_BASE   = 16'h8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    output logic              busy,
    output logic              done,
    output logic              err_wprot,
    output logic              led_mem_rd,
    output logic              led_mem_wr
);

    // RAM index width; address bits above it alias onto the same words.
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACCESS_LAST = CNT_W'(ACCESS_CYC - 1);

`ifdef MEM_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    mem_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_op_rd;
    logic              r_wprot;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_oe;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_led_rd;
    logic              r_led_wr;

    logic              w_req;
    logic              w_rom_hit;
    logic              w_acc_last;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_rdata;

    // Read wins over a simultaneous write, so any request starts a cycle.
    assign w_req      = req_rd | req_wr;
    assign w_rom_hit  = (address >= ROM_BASE);
    assign w_acc_last = (r_state == ACCESS) && (r_cnt == ACCESS_LAST);
    // The write lands on the final ACCESS edge; it is not gated by reset so a
    // write that already reached its final cycle still completes.
    assign w_ram_we   = w_acc_last && !r_op_rd && !r_wprot;

    relay_ram #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (r_idx),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    // Capture address and write data at request acceptance; held afterwards.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_req) begin
            r_idx   <= address[IDX_W-1:0];
            r_wdata <= wdata;
        end
    end

    // Cycle sequencer with registered handshake, data and lamp outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op_rd    <= 1'b0;
            r_wprot    <= 1'b0;
            r_rdata    <= '0;
            r_rdata_oe <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_led_rd   <= 1'b0;
            r_led_wr   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_op_rd  <= req_rd;
                        r_wprot  <= WPROT_EN && !req_rd && w_rom_hit;
                        r_busy   <= 1'b1;
                        r_led_rd <= req_rd;
                        r_led_wr <= !req_rd;
                        r_cnt    <= '0;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ACCESS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    if (r_cnt == ACCESS_LAST) begin
                        r_cnt <= '0;
                        if (r_op_rd) begin
                            r_rdata    <= w_ram_rdata;
                            r_rdata_oe <= 1'b1;
                        end
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    r_rdata_oe <= 1'b0;
                    r_done     <= 1'b1;
                    r_err      <= r_wprot;
                    r_busy     <= 1'b0;
                    r_led_rd   <= 1'b0;
                    r_led_wr   <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rdata      = r_rdata;
    assign rdata_oe   = r_rdata_oe;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err_wprot  = r_err;
    assign led_mem_rd = r_led_rd;
    assign led_mem_wr = r_led_wr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a read-data scoreboard and a byte
// model of the RAM (aliased on the low 15 address bits).
module tb_mem_access_unit;

`ifdef MEM_WPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] address;
    logic        req_rd;
    logic        req_wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_oe;
    logic        busy;
    logic        done;
    logic        err_wprot;
    logic        led_mem_rd;
    logic        led_mem_wr;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  sb_q [$];
    logic [7:0]  model [int];
    logic [7:0]  last_rd;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rdata_oe   (rdata_oe),
        .busy       (busy),
        .done       (done),
        .err_wprot  (err_wprot),
        .led_mem_rd (led_mem_rd),
        .led_mem_wr (led_mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; poke_k >= 0 pulses an extra req_rd that many cycles in.
    task automatic run_op(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [7:0] d, input int poke_k);
        int         lat;
        int         oe_k;
        bit         got;
        bit         seen_oe;
        logic [7:0] oe_data;
        logic       err_at_done;
        logic [7:0] exp_rd;
        bit         exp_err;
        int         extra;
        int         idx;
        idx     = int'(a[14:0]);
        exp_err = !rd && WP && (a >= 16'h8000);
        exp_rd  = 8'h00;
        if (rd) begin
            sb_q.push_back(model.exists(idx) ? model[idx] : 8'h00);
        end else if (!exp_err) begin
            model[idx] = d;
        end
        @(negedge clk);
        req_rd = rd; req_wr = wr; address = a; wdata = d;
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0;
        address = 16'($urandom); wdata = 8'($urandom);
        chk("busy_start", {15'd0, busy}, 16'd1);
        chk("led_rd", {15'd0, led_mem_rd}, {15'd0, rd});
        chk("led_wr", {15'd0, led_mem_wr}, {15'd0, !rd});
        lat = -1; oe_k = -1; got = 1'b0; seen_oe = 1'b0;
        oe_data = 8'h00; err_at_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (rdata_oe) begin
                seen_oe = 1'b1; oe_data = rdata; oe_k = k;
            end
            if (done) begin
                lat = k; got = 1'b1; err_at_done = err_wprot;
                break;
            end
            if (k == poke_k) begin
                req_rd = 1'b1; address = 16'h0020;
            end
            @(negedge clk);
            req_rd = 1'b0;
        end
        chk("done_seen", {15'd0, got}, 16'd1);
        chk("latency", 16'(lat), 16'd6);
        chk("err_wprot", {15'd0, err_at_done}, {15'd0, exp_err});
        chk("busy_at_done", {15'd0, busy}, 16'd0);
        if (rd) begin
            if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
            chk("oe_seen", {15'd0, seen_oe}, 16'd1);
            chk("oe_cycle", 16'(oe_k), 16'd5);
            chk("rdata", {8'd0, oe_data}, {8'd0, exp_rd});
            last_rd = exp_rd;
        end else begin
            chk("no_oe_on_write", {15'd0, seen_oe}, 16'd0);
            chk("rdata_hold", {8'd0, rdata}, {8'd0, last_rd});
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("extra_done", 16'(extra), 16'd0);
    endtask

    initial begin
        reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0;
        address = 16'h0000; wdata = 8'h00; last_rd = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rdata", {8'd0, rdata}, 16'd0);
        chk("rst_oe", {15'd0, rdata_oe}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_err", {15'd0, err_wprot}, 16'd0);
        chk("rst_led_rd", {15'd0, led_mem_rd}, 16'd0);
        chk("rst_led_wr", {15'd0, led_mem_wr}, 16'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic write then read back.
        run_op(1'b0, 1'b1, 16'h0010, 8'hA5, -1);
        run_op(1'b1, 1'b0, 16'h0010, 8'h00, -1);

        // Simultaneous read and write: read wins, RAM untouched.
        run_op(1'b0, 1'b1, 16'h0020, 8'h00, -1);
        run_op(1'b1, 1'b1, 16'h0020, 8'hFF, -1);
        run_op(1'b1, 1'b0, 16'h0020, 8'h00, -1);

        // Second request while busy is ignored.
        run_op(1'b1, 1'b0, 16'h0010, 8'h00, 2);

        // Reset during SETUP of a write aborts it.
        run_op(1'b0, 1'b1, 16'h0030, 8'h11, -1);
        @(negedge clk);
        req_wr = 1'b1; address = 16'h0030; wdata = 8'h99;
        @(negedge clk);
        req_wr = 1'b0; reset = 1'b1;
        chk("abort_busy_before", {15'd0, busy}, 16'd1);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_led_wr", {15'd0, led_mem_wr}, 16'd0);
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_rdata", {8'd0, rdata}, 16'd0);
        last_rd = 8'h00;
        repeat (3) @(negedge clk);
        run_op(1'b1, 1'b0, 16'h0030, 8'h00, -1);

        // Write protection (or plain write) at ROM_BASE, aliasing word 0.
        run_op(1'b0, 1'b1, 16'h0000, 8'h3C, -1);
        run_op(1'b0, 1'b1, 16'h8000, 8'h55, -1);
        run_op(1'b1, 1'b0, 16'h8000, 8'h00, -1);

        // Address aliasing above the RAM depth.
        run_op(1'b0, 1'b1, 16'h0005, 8'h77, -1);
        run_op(1'b1, 1'b0, 16'h8005, 8'h00, -1);

        chk("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
